alu_arbiter: RTL and testbench

// - Shares one alu instance among N_REQ requesters (e.g. EX stage, address-gen, CSR unit).
// - Round-robin arbitration with valid/ready request ports.
// - ALU output captured into a 1-entry result register returned with requester ID.
// - Sits between the issue logic and the single shared ALU datapath.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu.sv | 37 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/alu_arbiter.sv | 98 +++++++++
 tb/tb_alu_arbiter.sv | 167 ++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: opcode enum plus request/response records used by the arbiter.
// Record field widths track the default arbiter configuration (32-bit data, 3 requesters).
package alu_pkg;

    localparam int unsigned ALU_W    = 32;
    localparam int unsigned ALU_ID_W = 2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        alu_op_e            op;
        logic [ALU_W-1:0]   d1;
        logic [ALU_W-1:0]   d2;
    } alu_req_t;

    typedef struct packed {
        logic [ALU_ID_W-1:0] id;
        logic [ALU_W-1:0]    data;
        logic                zero;
        logic                sign;
    } alu_resp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between issue logic (master) and the shared-ALU arbiter (slave).
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_REQ = 3
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic    [N_REQ-1:0]            req_valid_i;
    logic    [N_REQ-1:0]            req_ready_o;
    alu_op_e [N_REQ-1:0]            req_op_i;
    logic    [N_REQ-1:0][WIDTH-1:0] req_d1_i;
    logic    [N_REQ-1:0][WIDTH-1:0] req_d2_i;
    logic                           resp_valid_o;
    logic                           resp_ready_i;
    logic    [ID_W-1:0]             resp_id_o;
    logic    [WIDTH-1:0]            resp_data_o;
    logic                           resp_zero_o;
    logic                           resp_sign_o;

    modport master (
        output req_valid_i, req_op_i, req_d1_i, req_d2_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_id_o, resp_data_o, resp_zero_o, resp_sign_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_d1_i, req_d2_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_id_o, resp_data_o, resp_zero_o, resp_sign_o
    );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU; zero/sign flags derive from the result.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned width_p = 32
) (
    input  alu_op_e            i_op,
    input  logic [width_p-1:0] i_a,
    input  logic [width_p-1:0] i_b,
    output logic [width_p-1:0] o_res,
    output logic               o_zero,
    output logic               o_sign
);
    logic [4:0] w_sh;
    assign w_sh = i_b[4:0];

    always_comb begin
        o_res = '0;
        case (i_op)
            ALU_ADD:  o_res = i_a + i_b;
            ALU_SUB:  o_res = i_a - i_b;
            ALU_AND:  o_res = i_a & i_b;
            ALU_OR:   o_res = i_a | i_b;
            ALU_XOR:  o_res = i_a ^ i_b;
            ALU_SLL:  o_res = i_a << w_sh;
            ALU_SRL:  o_res = i_a >> w_sh;
            ALU_SRA:  o_res = width_p'($signed(i_a) >>> w_sh);
            ALU_SLT:  o_res = width_p'($signed(i_a) < $signed(i_b));
            ALU_SLTU: o_res = width_p'(i_a < i_b);
            default:  o_res = '0;
        endcase
    end

    assign o_zero = (o_res == '0);
    assign o_sign = o_res[width_p-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the pointer; pointer moves past
// the winner only when the caller strobes i_adv (a completed handshake).
module rr_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_adv,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_gnt_idx
);
    logic [ID_W-1:0] r_ptr;
    logic            w_found;
    int              w_j;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_j       = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= int'(N_REQ)) w_j = w_j - int'(N_REQ);
            if (!w_found && i_req[w_j]) begin
                w_found   = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_gnt_idx = ID_W'(w_j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (o_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters with a 1-entry registered result.
// Optional build macro ALU_ARB_STATS_EN adds saturating per-requester grant counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W,
    parameter int unsigned N_REQ = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    alu_arbiter_if.slave          bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][15:0] stat_grants_o
`endif
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

    state_e           r_state;
    alu_resp_t        r_resp;
    alu_req_t         w_req;
    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_gnt_idx;
    logic             w_accept;
    logic             w_hs;
    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_sign;

    // Ready is forced low during reset even though the FSM already sits in EMPTY.
    assign w_accept        = rst_ni & ((r_state == ST_EMPTY) | bus.resp_ready_i);
    assign bus.req_ready_o = w_accept ? w_gnt : '0;
    assign w_hs            = |(bus.req_valid_i & bus.req_ready_o);

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_req     (bus.req_valid_i),
        .i_adv     (w_hs),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_req.op = bus.req_op_i[w_gnt_idx];
    assign w_req.d1 = bus.req_d1_i[w_gnt_idx];
    assign w_req.d2 = bus.req_d2_i[w_gnt_idx];

    alu #(.width_p(WIDTH)) u_alu (
        .i_op   (w_req.op),
        .i_a    (w_req.d1),
        .i_b    (w_req.d2),
        .o_res  (w_res),
        .o_zero (w_zero),
        .o_sign (w_sign)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_EMPTY;
            r_resp  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_hs) r_state <= ST_FULL;
                ST_FULL:  if (bus.resp_ready_i && !w_hs) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
            if (w_hs) begin
                r_resp.id   <= w_gnt_idx;
                r_resp.data <= w_res;
                r_resp.zero <= w_zero;
                r_resp.sign <= w_sign;
            end
        end
    end

    assign bus.resp_valid_o = (r_state == ST_FULL);
    assign bus.resp_id_o    = r_resp.id;
    assign bus.resp_data_o  = r_resp.data;
    assign bus.resp_zero_o  = r_resp.zero;
    assign bus.resp_sign_o  = r_resp.sign;

`ifdef ALU_ARB_STATS_EN
    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_stat
        logic [15:0] r_cnt;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt <= '0;
            end else if (w_hs && w_gnt[g] && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign stat_grants_o[g] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single request, round-robin, backpressure, flags.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_REQ = 3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    alu_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] stat_grants;
`endif

    alu_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grants_o (stat_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic [1:0] id, input logic [31:0] data,
                            input logic zero, input logic sign);
        chk({tag, ".valid"}, 64'(bus.resp_valid_o), 64'd1);
        chk({tag, ".id"},    64'(bus.resp_id_o),    64'(id));
        chk({tag, ".data"},  64'(bus.resp_data_o),  64'(data));
        chk({tag, ".zero"},  64'(bus.resp_zero_o),  64'(zero));
        chk({tag, ".sign"},  64'(bus.resp_sign_o),  64'(sign));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req_valid_i  = 3'b111;
        bus.resp_ready_i = 1'b1;
        for (int i = 0; i < int'(N_REQ); i++) begin
            bus.req_op_i[i] = ALU_ADD;
            bus.req_d1_i[i] = 32'(i * 10);
            bus.req_d2_i[i] = 32'd1;
        end

        // Reset state
        #2;
        chk("rst.ready", 64'(bus.req_ready_o), 64'b000);
        chk("rst.valid", 64'(bus.resp_valid_o), 64'd0);
        chk("rst.data",  64'(bus.resp_data_o), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;

        // Round-robin 0,1,2,0,1 back-to-back (req i computes i*10+1)
        chk("rr.g0", 64'(bus.req_ready_o), 64'b001);
        tick(); chk_resp("rr.r0", 2'd0, 32'd1, 1'b0, 1'b0);
        chk("rr.g1", 64'(bus.req_ready_o), 64'b010);
        tick(); chk_resp("rr.r1", 2'd1, 32'd11, 1'b0, 1'b0);
        chk("rr.g2", 64'(bus.req_ready_o), 64'b100);
        tick(); chk_resp("rr.r2", 2'd2, 32'd21, 1'b0, 1'b0);
        chk("rr.g3", 64'(bus.req_ready_o), 64'b001);
        tick(); chk_resp("rr.r3", 2'd0, 32'd1, 1'b0, 1'b0);
        chk("rr.g4", 64'(bus.req_ready_o), 64'b010);
        tick(); chk_resp("rr.r4", 2'd1, 32'd11, 1'b0, 1'b0);

        // Drain: nothing valid, consumer ready -> EMPTY
        bus.req_valid_i = 3'b000;
        #1;
        chk("drain.ready", 64'(bus.req_ready_o), 64'b000);
        tick();
        chk("drain.valid", 64'(bus.resp_valid_o), 64'd0);

        // Single request from req1: 5 + 7 (pointer is at 2, wraps to 1)
        bus.req_op_i[1] = ALU_ADD;
        bus.req_d1_i[1] = 32'd5;
        bus.req_d2_i[1] = 32'd7;
        bus.req_valid_i = 3'b010;
        #1;
        chk("single.ready", 64'(bus.req_ready_o), 64'b010);
        tick();
        chk_resp("single", 2'd1, 32'd12, 1'b0, 1'b0);

        // Backpressure: 4 stalled cycles, result held, no grants
        bus.resp_ready_i = 1'b0;
        bus.req_op_i[0]  = ALU_SUB;
        bus.req_d1_i[0]  = 32'd3;
        bus.req_d2_i[0]  = 32'd3;
        bus.req_op_i[2]  = ALU_SRA;
        bus.req_d1_i[2]  = 32'h8000_0000;
        bus.req_d2_i[2]  = 32'd4;
        bus.req_valid_i  = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("stall.ready", 64'(bus.req_ready_o), 64'b000);
            tick();
            chk_resp("stall", 2'd1, 32'd12, 1'b0, 1'b0);
        end

        // Release: grant resumes same cycle at pointer 2 (SRA), then req0 (SUB)
        bus.resp_ready_i = 1'b1;
        #1;
        chk("resume.ready", 64'(bus.req_ready_o), 64'b100);
        tick();
        chk_resp("sra", 2'd2, 32'hF800_0000, 1'b0, 1'b1);
        chk("sub.ready", 64'(bus.req_ready_o), 64'b001);
        tick();
        chk_resp("sub", 2'd0, 32'd0, 1'b1, 1'b0);

        // Reset while FULL and stalled
        bus.resp_ready_i = 1'b0;
        bus.req_valid_i  = 3'b000;
        tick();
        chk("prerst.valid", 64'(bus.resp_valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", 64'(bus.resp_valid_o), 64'd0);
        chk("midrst.data",  64'(bus.resp_data_o), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.resp_ready_i = 1'b1;
        bus.req_valid_i  = 3'b111;
        #1;
        chk("postrst.ready", 64'(bus.req_ready_o), 64'b001);
        tick();
        chk("postrst.id", 64'(bus.resp_id_o), 64'd0);

`ifdef ALU_ARB_STATS_EN
        rst_n = 1'b0;
        #1;
        chk("stat.rst", 64'(stat_grants[0]), 64'd0);
        rst_n = 1'b1;
        bus.req_valid_i = 3'b001;
        for (int c = 0; c < 70000; c++) tick();
        chk("stat.sat0", 64'(stat_grants[0]), 64'hFFFF);
        chk("stat.cnt1", 64'(stat_grants[1]), 64'd0);
        chk("stat.cnt2", 64'(stat_grants[2]), 64'd0);
`endif

        bus.req_valid_i = 3'b000;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
